// File: rtl/chaos_sbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chaos_sbox_pkg
// Description : Shared types and constants for the chaotic S-box generator.
// Revision    : 1.0 - initial release
// ============================================================================
package chaos_sbox_pkg;

    localparam int          SBOX_SIZE       = 256;
    localparam int          BYTE_W          = 8;
    localparam logic [31:0] DEFAULT_PERTURB = 32'h0000_1F3D;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WARM = 3'd1,
        ST_GEN  = 3'd2,
        ST_SCAN = 3'd3,
        ST_EMIT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/chaos_sbox_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : chaos_sbox_gen_if
// Description : Control and byte-stream bundle of the chaotic S-box generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface chaos_sbox_gen_if #(
    parameter int W = 32
);
    logic         start;
    logic [W-1:0] seed;
    logic         out_ready;
    logic         out_valid;
    logic [7:0]   out_data;
    logic         busy;
    logic         done;

    modport master (
        input  start, seed, out_ready,
        output out_valid, out_data, busy, done
    );

    modport slave (
        output start, seed, out_ready,
        input  out_valid, out_data, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/logistic_step.sv
`default_nettype none
// ============================================================================
// Module      : logistic_step
// Description : One fixed-point logistic map step (r = 4), saturating, with
//               a perturbation applied at zero and at fixed points.
// Revision    : 1.0 - initial release
// ============================================================================
module logistic_step #(
    parameter int         W       = 32,
    parameter logic [W-1:0] PERTURB = W'(32'h0000_1F3D)
) (
    input  wire logic [W-1:0] x,
    output logic      [W-1:0] fx
);

    logic [W:0]     w_comp;
    logic [2*W:0]   w_prod;
    logic [W+2:0]   w_n;
    logic [W-1:0]   w_sat;

    // 2^W - x needs one extra bit because x may be zero
    assign w_comp = {1'b1, {W{1'b0}}} - {1'b0, x};
    assign w_prod = (2*W+1)'(w_comp) * (2*W+1)'(x);
    assign w_n    = (W+3)'(w_prod >> (W-2));
    assign w_sat  = (|w_n[W+2:W]) ? {W{1'b1}} : w_n[W-1:0];
    assign fx     = ((w_sat == '0) || (w_sat == x)) ? (w_sat + PERTURB) : w_sat;

endmodule
`default_nettype wire

// File: rtl/chaos_sbox_gen.sv
`default_nettype none
// ============================================================================
// Module      : chaos_sbox_gen
// Description : Streams a 256-entry byte permutation drawn from a seeded
//               logistic map, with bitmap rejection and linear-scan fallback.
// Revision    : 1.0 - initial release
// ============================================================================
module chaos_sbox_gen
    import chaos_sbox_pkg::*;
#(
    parameter int           W         = 32,
    parameter int           WARMUP    = 64,
    parameter int           MAX_TRIES = 16,
    parameter logic [W-1:0] PERTURB   = W'(DEFAULT_PERTURB)
) (
    input  wire logic         clk,
    input  wire logic         rst,
    chaos_sbox_gen_if.master  bus
);

    localparam int TW = $clog2(MAX_TRIES) + 1;
    localparam int WW = $clog2(WARMUP) + 1;
    localparam logic [TW-1:0] TRIES_LAST = TW'(MAX_TRIES - 1);
    localparam logic [WW-1:0] WARM_LAST  = WW'(WARMUP - 1);
    localparam logic [W-1:0]  HALF       = {1'b1, {(W-1){1'b0}}};

    state_t                 r_state;
    state_t                 w_next;
    logic [W-1:0]           r_x;
    logic [W-1:0]           w_fx;
    logic [W-1:0]           w_seed_fix;
    logic [BYTE_W-1:0]      w_c;
    logic [SBOX_SIZE-1:0]   r_used;
    logic [8:0]             r_count;
    logic [TW-1:0]          r_tries;
    logic [BYTE_W-1:0]      r_cand;
    logic [WW-1:0]          r_warm;
    logic [BYTE_W-1:0]      r_data;
    logic                   w_restart;

    logistic_step #(
        .W       (W),
        .PERTURB (PERTURB)
    ) u_step (
        .x  (r_x),
        .fx (w_fx)
    );

    assign w_c        = w_fx[W-1 -: BYTE_W];
    assign w_seed_fix = ((bus.seed == '0) || (bus.seed == HALF)) ? PERTURB : bus.seed;
    assign w_restart  = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (w_restart) w_next = ST_WARM;
            ST_WARM:          if (r_warm == WARM_LAST) w_next = ST_GEN;
            ST_GEN: begin
                if (!r_used[w_c])               w_next = ST_EMIT;
                else if (r_tries == TRIES_LAST) w_next = ST_SCAN;
            end
            ST_SCAN:          if (!r_used[r_cand]) w_next = ST_EMIT;
            ST_EMIT: begin
                if (bus.out_ready) w_next = (r_count == 9'd255) ? ST_DONE : ST_GEN;
            end
            default:          w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_used  <= '0;
            r_count <= '0;
            r_tries <= '0;
            r_cand  <= '0;
            r_warm  <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_restart) begin
                        r_x     <= w_seed_fix;
                        r_used  <= '0;
                        r_count <= '0;
                        r_tries <= '0;
                        r_warm  <= '0;
                    end
                end
                ST_WARM: begin
                    r_x    <= w_fx;
                    r_warm <= r_warm + 1'b1;
                end
                ST_GEN: begin
                    r_x <= w_fx;
                    if (!r_used[w_c]) begin
                        r_data <= w_c;
                    end else if (r_tries == TRIES_LAST) begin
                        r_cand  <= w_c + 1'b1;
                        r_tries <= '0;
                    end else begin
                        r_tries <= r_tries + 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (!r_used[r_cand]) r_data <= r_cand;
                    else                 r_cand <= r_cand + 1'b1;
                end
                ST_EMIT: begin
                    // Marking the byte used only on acceptance keeps a stalled beat re-emittable
                    if (bus.out_ready) begin
                        r_used[r_data] <= 1'b1;
                        r_count        <= r_count + 1'b1;
                        r_tries        <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = (r_state == ST_EMIT);
    assign bus.out_data  = r_data;
    assign bus.busy      = (r_state == ST_WARM) || (r_state == ST_GEN) ||
                           (r_state == ST_SCAN) || (r_state == ST_EMIT);
    assign bus.done      = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_chaos_sbox_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_chaos_sbox_gen
// Description : Self-checking bench: map-step vector table, full-run
//               permutation checks against a behavioural sequence model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chaos_sbox_gen;

    localparam int          W      = 32;
    localparam int          WARMUP = 64;
    localparam logic [31:0] PERT   = 32'h0000_1F3D;
    localparam int          LIMIT  = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tb_start = 1'b0;
    logic        tb_ready = 1'b1;
    logic        tb_sel = 1'b0;
    logic [31:0] tb_seed = '0;

    always #5 clk = ~clk;

    chaos_sbox_gen_if #(.W(W)) bus_a ();
    chaos_sbox_gen_if #(.W(W)) bus_b ();

    assign bus_a.start     = tb_start && !tb_sel;
    assign bus_a.seed      = tb_seed;
    assign bus_a.out_ready = tb_ready;
    assign bus_b.start     = tb_start && tb_sel;
    assign bus_b.seed      = tb_seed;
    assign bus_b.out_ready = tb_ready;

    chaos_sbox_gen #(.W(W), .WARMUP(WARMUP), .MAX_TRIES(16), .PERTURB(PERT)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    chaos_sbox_gen #(.W(W), .WARMUP(WARMUP), .MAX_TRIES(1), .PERTURB(PERT)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    logic        cur_valid, cur_busy, cur_done;
    logic [7:0]  cur_data;
    assign cur_valid = tb_sel ? bus_b.out_valid : bus_a.out_valid;
    assign cur_data  = tb_sel ? bus_b.out_data  : bus_a.out_data;
    assign cur_busy  = tb_sel ? bus_b.busy      : bus_a.busy;
    assign cur_done  = tb_sel ? bus_b.done      : bus_a.done;

    logic [31:0] step_x;
    logic [31:0] step_fx;
    logistic_step #(.W(32), .PERTURB(PERT)) u_step (.x(step_x), .fx(step_fx));

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_seq [256];
    logic [7:0] cap     [256];
    int         cap_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Map step straight from the arithmetic definition using 64-bit integers
    function automatic logic [31:0] mf(input logic [31:0] x);
        longint unsigned xx, p, n;
        xx = {32'd0, x};
        p  = xx * (64'h1_0000_0000 - xx);
        n  = p >> 30;
        if (n > 64'hFFFF_FFFF) n = 64'hFFFF_FFFF;
        if (n == 0 || n == xx) n = (n + {32'd0, PERT}) & 64'hFFFF_FFFF;
        return n[31:0];
    endfunction

    task automatic model_run(input logic [31:0] seed, input int max_tries);
        logic [31:0] x;
        bit          used [256];
        int          tries;
        logic [7:0]  c;
        bit          got;
        foreach (used[i]) used[i] = 1'b0;
        x = (seed == 32'd0 || seed == 32'h8000_0000) ? PERT : seed;
        repeat (WARMUP) x = mf(x);
        for (int k = 0; k < 256; k++) begin
            tries = 0;
            got   = 1'b0;
            while (!got) begin
                x = mf(x);
                c = x[31:24];
                if (!used[c]) begin
                    got = 1'b1;
                end else begin
                    tries++;
                    if (tries == max_tries) begin
                        c = c + 8'd1;
                        while (used[c]) c = c + 8'd1;
                        got = 1'b1;
                    end
                end
            end
            used[c]    = 1'b1;
            exp_seq[k] = c;
        end
    endtask

    function automatic int seq_mismatches(input int n);
        int m = 0;
        for (int i = 0; i < n; i++) if (cap[i] !== exp_seq[i]) m++;
        return m;
    endfunction

    function automatic int distinct_count();
        bit seen [256];
        int d = 0;
        foreach (seen[i]) seen[i] = 1'b0;
        for (int i = 0; i < cap_n; i++) begin
            if (!seen[cap[i]]) d++;
            seen[cap[i]] = 1'b1;
        end
        return d;
    endfunction

    // One run from start; optional stall, mid-run reset, or ignored start pulse
    task automatic run(input logic [31:0] seed, input int stall_at, input int rst_at,
                       input int start_at, input bit rnd_ready, output int cycles);
        logic [7:0] held;
        int         gap_bad = 0;
        bit         accepted;
        bit         aborted = 1'b0;
        @(negedge clk);
        tb_seed  = seed;
        tb_start = 1'b1;
        tb_ready = 1'b1;
        cap_n    = 0;
        @(negedge clk);
        tb_start = 1'b0;
        tb_seed  = $urandom;
        cycles   = 1;
        chk("busy_after_start", {63'd0, cur_busy}, 64'd1);
        while (cap_n < 256 && cycles < LIMIT && !aborted) begin
            accepted = 1'b0;
            if (cur_valid) begin
                if (cap_n == stall_at) begin
                    held     = cur_data;
                    tb_ready = 1'b0;
                    for (int s = 0; s < 10; s++) begin
                        @(negedge clk);
                        cycles++;
                        chk("stall_hold", {55'd0, cur_valid, cur_data}, {55'd0, 1'b1, held});
                    end
                    tb_ready = 1'b1;
                end else begin
                    tb_ready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
                end
                if (tb_ready) begin
                    cap[cap_n] = cur_data;
                    cap_n++;
                    accepted = 1'b1;
                    if (cap_n == start_at) tb_start = 1'b1;
                end
            end else begin
                tb_ready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
            end
            @(negedge clk);
            tb_start = 1'b0;
            cycles++;
            if (accepted && cur_valid) gap_bad++;
            if (accepted && rst_at > 0 && cap_n == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_mid_run", {61'd0, cur_valid, cur_busy, cur_done}, 64'd0);
                aborted = 1'b1;
            end
        end
        tb_ready = 1'b1;
        chk("valid_drops_after_accept", gap_bad, 0);
        if (!aborted) begin
            chk("beat_count", cap_n, 256);
            if (cap_n == 256)
                chk("done_after_last", {62'd0, cur_done, cur_busy}, {62'd0, 1'b1, 1'b0});
        end
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] fx;
    } step_vec_t;

    step_vec_t vecs [9];
    int        cyc;
    logic [7:0] first_ref;
    logic [31:0] rseed;

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h0000_1F3D};
        vecs[1] = '{32'h8000_0000, 32'hFFFF_FFFF};
        vecs[2] = '{32'hC000_0000, 32'hC000_1F3D};
        vecs[3] = '{32'h4000_0000, 32'hC000_0000};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0003};
        vecs[5] = '{32'h0000_0001, 32'h0000_0003};
        vecs[6] = '{32'h2000_0000, 32'h7000_0000};
        vecs[7] = '{32'h1000_0000, 32'h3C00_0000};
        vecs[8] = '{32'h0000_0002, 32'h0000_0007};

        repeat (3) @(negedge clk);
        chk("reset_out_valid", {63'd0, bus_a.out_valid}, 64'd0);
        chk("reset_out_data",  {56'd0, bus_a.out_data},  64'd0);
        chk("reset_busy",      {63'd0, bus_a.busy},      64'd0);
        chk("reset_done",      {63'd0, bus_a.done},      64'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            step_x = vecs[i].x;
            #1;
            chk("map_step", {32'd0, step_fx}, {32'd0, vecs[i].fx});
        end

        // Baseline seed, run twice for determinism
        model_run(32'h9E37_79B9, 16);
        first_ref = exp_seq[0];
        for (int r = 0; r < 2; r++) begin
            run(32'h9E37_79B9, -1, 0, -1, 1'b0, cyc);
            chk("seq_9e37", seq_mismatches(256), 0);
            chk("distinct_9e37", distinct_count(), 256);
        end

        // Fixed point 0.75 and zero seed
        model_run(32'hC000_0000, 16);
        run(32'hC000_0000, -1, 0, -1, 1'b0, cyc);
        chk("seq_c000", seq_mismatches(256), 0);
        chk("first_differs_c000", {63'd0, cap[0] != first_ref}, 64'd1);
        model_run(32'h0000_0000, 16);
        run(32'h0000_0000, -1, 0, -1, 1'b0, cyc);
        chk("seq_zero", seq_mismatches(256), 0);
        chk("first_differs_zero", {63'd0, cap[0] != first_ref}, 64'd1);

        // Ten-cycle stall in the middle of the stream
        model_run(32'h1234_5678, 16);
        run(32'h1234_5678, 37, 0, -1, 1'b0, cyc);
        chk("seq_stall", seq_mismatches(256), 0);

        // Scan on first collision
        tb_sel = 1'b1;
        model_run(32'h9E37_79B9, 1);
        run(32'h9E37_79B9, -1, 0, -1, 1'b0, cyc);
        chk("seq_mt1", seq_mismatches(256), 0);
        chk("distinct_mt1", distinct_count(), 256);
        chk("cycles_mt1_bound", {63'd0, cyc < WARMUP + 256 * 257}, 64'd1);
        tb_sel = 1'b0;

        // Reset after beat 100, then reproduce from scratch
        model_run(32'hA5A5_0F0F, 16);
        run(32'hA5A5_0F0F, -1, 100, -1, 1'b0, cyc);
        chk("seq_pre_rst", seq_mismatches(100), 0);
        run(32'hA5A5_0F0F, -1, 0, -1, 1'b0, cyc);
        chk("seq_post_rst", seq_mismatches(256), 0);

        // Start pulse while busy must be ignored
        run(32'hA5A5_0F0F, -1, 0, 50, 1'b0, cyc);
        chk("seq_start_busy", seq_mismatches(256), 0);

        // Random seeds with random back-pressure
        for (int r = 0; r < 2; r++) begin
            rseed = $urandom;
            model_run(rseed, 16);
            run(rseed, -1, 0, -1, 1'b1, cyc);
            chk("seq_random", seq_mismatches(256), 0);
            chk("distinct_random", distinct_count(), 256);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chaos_sbox_gen.md
Name: chaos_sbox_gen

Overview:
- Upstream producer for the S-box storage stage: generates a 256-entry byte permutation from a seeded fixed-point logistic map (r = 4).
- Streams the permutation one byte per accepted beat; out_valid/out_data connect to the storage stage's write-enable/data inputs.
- Duplicate rejection uses a 256-bit used-bitmap; a bounded linear-scan fallback guarantees termination.

Parameters:
- W, 32, fixed-point width of map state x (unsigned Q0.W).
- WARMUP, 64, map iterations discarded after seed load.
- MAX_TRIES, 16, consecutive rejected candidates before switching to linear scan.
- PERTURB, 32'h0000_1F3D, added to x when the map hits a degenerate value.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; loads seed and begins generation (honoured in IDLE and DONE only).
- seed  in  W  initial map state, sampled on the start cycle.
- out_ready  in  1  downstream accepts the current beat (tie high for the storage stage).
- out_valid  out  1  out_data holds a new permutation byte.
- out_data  out  8  permutation byte.
- busy  out  1  high from the cycle after start until done.
- done  out  1  high after the 256th accepted beat; held until next start or rst.

Behaviour:
- Reset (sync):
  - Outputs: out_valid=0, out_data=0, busy=0, done=0.
  - State: state=IDLE, bitmap cleared, count=0, tries=0, x=0.
  - rst mid-generation aborts immediately; no further beats.
- Map step f(x):
  - p = x * (2^W - x), 2W bits; n = p >> (W-2).
  - If n >= 2^W, saturate to 2^W-1.
  - If n==0 or n==x, use n + PERTURB (mod 2^W).
  - Candidate byte c = n[W-1:W-8].
- Seed load: seed==0 or seed==2^(W-1) is replaced by PERTURB.
- FSM:
  - IDLE: on start -> load x, clear bitmap, count, tries, done -> WARM.
  - WARM: x<=f(x) each cycle for WARMUP cycles -> GEN.
  - GEN: x<=f(x), c from f(x).
    - !used[c]: latch c into out_data -> EMIT.
    - used[c] with tries==MAX_TRIES-1: cand<=c+1 (mod 256), tries<=0 -> SCAN.
    - Otherwise tries++.
  - SCAN: one candidate per cycle.
    - !used[cand]: out_data<=cand -> EMIT.
    - Otherwise cand++ (mod 256).
    - Terminates within 255 cycles.
  - EMIT: out_valid=1, out_data stable while out_ready=0.
    - On out_valid&&out_ready: used[out_data]<=1, count++, tries<=0, out_valid drops next cycle.
    - If count was 255 -> DONE, else -> GEN.
  - DONE: done=1, busy=0; start -> restart as from IDLE (done clears).
- start while busy is ignored. seed is not sampled outside the start cycle.
- Output guarantees:
  - Exactly 256 accepted beats per run, all distinct. A beat is never re-emitted after acceptance.
  - Minimum beat gap: 2 cycles (EMIT -> GEN -> EMIT).
  - Deterministic: same seed gives an identical sequence.
- Widths: count is 9 bits, tries is clog2(MAX_TRIES)+1 bits, cand is 8 bits, wrapping naturally.

Decomposition:
- Package chaos_sbox_pkg holds:
  - state enum: IDLE, WARM, GEN, SCAN, EMIT, DONE.
  - constants: SBOX_SIZE=256, BYTE_W=8, default PERTURB.
- Sub-module logistic_step (combinational, parameter W): x in, f(x) out, including saturation and perturbation.
  - Reused by the cipher keystream stage.

Test Plan:
- Seed 32'h9E37_79B9, out_ready=1 -> exactly 256 out_valid beats, all values 0x00–0xFF once each, done=1 the cycle after beat 256, busy low; rerun with same seed gives a bit-identical sequence.
- Seed 32'hC000_0000 (0.75, fixed point of f) and seed 0 -> no lock-up; 256 distinct beats; first beat differs from the 32'h9E37_79B9 run.
- out_ready held low 10 cycles during an EMIT -> out_valid=1 and out_data constant for all 10 cycles; no beat lost or duplicated; total 256.
- MAX_TRIES=1 -> SCAN entered on the first collision; permutation still complete; total cycles from start to done < WARMUP + 256*257.
- rst asserted at beat 100 -> next cycle out_valid=0, busy=0, done=0; new start with the same seed reproduces beats 1..100 identically.
- start pulsed at beat 50 while busy -> ignored; sequence and beat count unchanged.
